fp_add_scheduler: RTL

//  Shares one floating-point adder (32-bit word: bit0 sign, bits1-6 exponent, bits7-31 fraction)

---
 rtl/fp_add_scheduler_if.sv | 29 ++
 rtl/fp_add_scheduler.sv | 110 +++++++++++
 2 files changed

// File: rtl/fp_add_scheduler_if.sv
// fp_add_scheduler_if: requester, response and adder-side signals of the shared-adder scheduler
interface fp_add_scheduler_if #(
  parameter int N_REQ = 4
);
  localparam int IDW = $clog2(N_REQ);
  logic [N_REQ-1:0]    req_valid;
  logic [N_REQ-1:0]    req_ready;
  logic [N_REQ-1:0]    resp_valid;
  logic [32*N_REQ-1:0] req_op_A;
  logic [32*N_REQ-1:0] req_op_B;
  logic [31:0]         resp_data;
  logic [3:0]          resp_status;
  logic                fpu_start;
  logic [31:0]         fpu_op_A;
  logic [31:0]         fpu_op_B;
  logic                fpu_done;
  logic [31:0]         fpu_data;
  logic [3:0]          fpu_status;
  logic                busy;
  logic [IDW-1:0]      grant_id;
  modport slave (
    input  req_valid, req_op_A, req_op_B, fpu_done, fpu_data, fpu_status,
    output req_ready, resp_valid, resp_data, resp_status, fpu_start, fpu_op_A, fpu_op_B, busy, grant_id
  );
  modport master (
    output req_valid, req_op_A, req_op_B, fpu_done, fpu_data, fpu_status,
    input  req_ready, resp_valid, resp_data, resp_status, fpu_start, fpu_op_A, fpu_op_B, busy, grant_id
  );
endinterface

// File: rtl/fp_add_scheduler.sv
// fp_add_scheduler: round-robin sharing of one floating-point adder between N_REQ requesters
module fp_add_scheduler #(
  parameter int N_REQ   = 4,
  parameter int TIMEOUT = 64
) (
  input logic               clock_100kHz,
  input logic               reset,
  fp_add_scheduler_if.slave sif
);
  localparam int IDW = $clog2(N_REQ);
  localparam int TW  = $clog2(TIMEOUT) + 1;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESPOND} state_t;
  state_t           state_q, state_d;
  logic [IDW-1:0]   last_q, last_d, grant_q, grant_d, pick, idx;
  logic             found;
  logic [TW-1:0]    timer_q, timer_d;
  logic [31:0]      op_a_q, op_a_d, op_b_q, op_b_d, data_q, data_d, sel_a, sel_b;
  logic [3:0]       stat_q, stat_d;
  logic [N_REQ-1:0] gsel;
  // scan starts just after the last winner so every pending requester is reached within N_REQ grants
  always_comb begin
    pick  = '0;
    idx   = '0;
    found = 1'b0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = IDW'((int'(last_q) + k) % N_REQ);
      if (!found && sif.req_valid[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (IDW'(i) == pick) begin
        sel_a = sif.req_op_A[32*i +: 32];
        sel_b = sif.req_op_B[32*i +: 32];
      end
    end
  end
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    grant_d = grant_q;
    timer_d = timer_q;
    op_a_d  = op_a_q;
    op_b_d  = op_b_q;
    data_d  = data_q;
    stat_d  = stat_q;
    case (state_q)
      IDLE: if (found) begin
        state_d = ISSUE;
        grant_d = pick;
        op_a_d  = sel_a;
        op_b_d  = sel_b;
      end
      ISSUE: begin
        timer_d = '0;
        state_d = WAIT;
      end
      WAIT: begin
        timer_d = timer_q + 1'b1;
        if (sif.fpu_done) begin
          data_d  = sif.fpu_data;
          stat_d  = sif.fpu_status;
          state_d = RESPOND;
        end else if (timer_q == TW'(TIMEOUT - 1)) begin
          data_d  = '0;
          stat_d  = 4'hF;
          state_d = RESPOND;
        end
      end
      default: begin
        last_d  = grant_q;
        state_d = IDLE;
      end
    endcase
  end
  always_ff @(posedge clock_100kHz) begin
    if (reset) begin
      state_q <= IDLE;
      last_q  <= IDW'(N_REQ - 1);
      grant_q <= '0;
      timer_q <= '0;
      op_a_q  <= '0;
      op_b_q  <= '0;
      data_q  <= '0;
      stat_q  <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      grant_q <= grant_d;
      timer_q <= timer_d;
      op_a_q  <= op_a_d;
      op_b_q  <= op_b_d;
      data_q  <= data_d;
      stat_q  <= stat_d;
    end
  end
  assign gsel            = N_REQ'(1) << grant_q;
  assign sif.req_ready   = (state_q == ISSUE) ? gsel : '0;
  assign sif.resp_valid  = (state_q == RESPOND) ? gsel : '0;
  assign sif.fpu_start   = state_q == ISSUE;
  assign sif.busy        = state_q != IDLE;
  assign sif.grant_id    = grant_q;
  assign sif.fpu_op_A    = op_a_q;
  assign sif.fpu_op_B    = op_b_q;
  assign sif.resp_data   = data_q;
  assign sif.resp_status = stat_q;
endmodule
